// File: rtl/sample_sched_pkg.sv
// Shared FSM encoding, per-slice level types and level functions for the
// level-scheduled evaluator of the six-input/three-output sample netlist.
package sample_sched_pkg;

    localparam int NUM_LEVELS = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_L1   = 3'd1;
    localparam logic [2:0] ST_L2   = 3'd2;
    localparam logic [2:0] ST_L3   = 3'd3;
    localparam logic [2:0] ST_L4   = 3'd4;
    localparam logic [2:0] ST_DONE = 3'(NUM_LEVELS + 1);

    // One bit-slice per struct; later levels carry forward what they still need.
    typedef struct packed { logic a, b, c, d, e, f; } opnd_t;
    typedef struct packed { logic b, g, h, i, j; } lvl1_t;
    typedef struct packed { logic b, h, k, l, m, p; } lvl2_t;
    typedef struct packed { logic n, o, p; } lvl3_t;
    typedef struct packed { logic o, p, q; } lvl4_t;

    function automatic lvl1_t l1(input opnd_t x);
        lvl1_t r;
        r.b = x.b;
        r.g = x.a | x.d;
        r.h = x.a & x.c;
        r.i = ~x.c;
        r.j = x.d | x.e | x.f;
        return r;
    endfunction

    function automatic lvl2_t l2(input lvl1_t x);
        lvl2_t r;
        r.b = x.b;
        r.h = x.h;
        r.k = x.g | x.h | x.i;
        r.l = x.h & x.j & x.i;
        r.m = x.i & x.j;
        r.p = ~x.g;
        return r;
    endfunction

    function automatic lvl3_t l3(input lvl2_t x);
        lvl3_t r;
        r.n = x.l & x.m;
        r.o = x.b & x.k & x.h;
        r.p = x.p;
        return r;
    endfunction

    // n is provably zero, but q is still computed from it rather than tied high.
    function automatic lvl4_t l4(input lvl3_t x);
        lvl4_t r;
        r.o = x.o;
        r.p = x.p;
        r.q = ~x.n;
        return r;
    endfunction

endpackage

// File: rtl/sample_stage_reg.sv
// WIDTH-generic data register with a valid bit; clear drops valid, stall
// freezes everything, load captures new data when the incoming beat is valid.
module sample_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic         stall,
    input  logic         d_valid,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // NOTE: data is reset along with valid so the outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load && !stall) begin
            valid <= d_valid;
            if (d_valid) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/sample_sched_eval.sv
// Level-scheduled evaluator of the sample netlist: WIDTH parallel slices, one
// logic level per clock, either one job in flight (MODE=0) or pipelined (MODE=1).
module sample_sched_eval
    import sample_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] done_cnt
);

    opnd_t [WIDTH-1:0] s0_d, s0_q;
    lvl1_t [WIDTH-1:0] s1_d, s1_q;
    lvl2_t [WIDTH-1:0] s2_d, s2_q;
    lvl3_t [WIDTH-1:0] s3_d, s3_q;
    lvl4_t [WIDTH-1:0] s4_d, s4_q;

    logic [NUM_LEVELS:0] ld;
    logic [NUM_LEVELS:0] dv;
    logic [NUM_LEVELS:0] vq;
    logic                stall;
    logic                clear;

    for (genvar k = 0; k < WIDTH; k++) begin : g_slice
        assign s0_d[k] = opnd_t'{a: a[k], b: b[k], c: c[k], d: d[k], e: e[k], f: f[k]};
        assign s1_d[k] = l1(s0_q[k]);
        assign s2_d[k] = l2(s1_q[k]);
        assign s3_d[k] = l3(s2_q[k]);
        assign s4_d[k] = l4(s3_q[k]);
        assign o[k]    = s4_q[k].o;
        assign p[k]    = s4_q[k].p;
        assign q[k]    = s4_q[k].q;
    end

    sample_stage_reg #(.W(WIDTH * $bits(opnd_t))) u_s0 (
        .clk(clk), .rst(rst), .clear(clear), .load(ld[0]), .stall(stall),
        .d_valid(dv[0]), .d(s0_d), .valid(vq[0]), .q(s0_q)
    );
    sample_stage_reg #(.W(WIDTH * $bits(lvl1_t))) u_s1 (
        .clk(clk), .rst(rst), .clear(clear), .load(ld[1]), .stall(stall),
        .d_valid(dv[1]), .d(s1_d), .valid(vq[1]), .q(s1_q)
    );
    sample_stage_reg #(.W(WIDTH * $bits(lvl2_t))) u_s2 (
        .clk(clk), .rst(rst), .clear(clear), .load(ld[2]), .stall(stall),
        .d_valid(dv[2]), .d(s2_d), .valid(vq[2]), .q(s2_q)
    );
    sample_stage_reg #(.W(WIDTH * $bits(lvl3_t))) u_s3 (
        .clk(clk), .rst(rst), .clear(clear), .load(ld[3]), .stall(stall),
        .d_valid(dv[3]), .d(s3_d), .valid(vq[3]), .q(s3_q)
    );
    sample_stage_reg #(.W(WIDTH * $bits(lvl4_t))) u_s4 (
        .clk(clk), .rst(rst), .clear(clear), .load(ld[4]), .stall(stall),
        .d_valid(dv[4]), .d(s4_d), .valid(vq[4]), .q(s4_q)
    );

    if (MODE == 0) begin : g_fsm
        logic [2:0] state;

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (in_valid) state <= ST_L1;
                    ST_L1, ST_L2, ST_L3, ST_L4: state <= state + 3'd1;
                    ST_DONE: if (out_ready) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end

        assign in_ready  = ~rst & (state == ST_IDLE);
        assign out_valid = (state == ST_DONE) & vq[NUM_LEVELS];
        assign stall     = 1'b0;
        assign clear     = out_valid & out_ready;
        assign dv        = '1;
        assign ld[0]     = in_valid & in_ready;

        // Each level register loads only in its own state, behind a valid predecessor.
        for (genvar s = 1; s <= NUM_LEVELS; s++) begin : g_ld
            assign ld[s] = (state == 3'(s)) & vq[s-1];
        end
    end else begin : g_pipe
        assign out_valid = vq[NUM_LEVELS];
        assign stall     = out_valid & ~out_ready;
        assign in_ready  = ~rst & ~stall;
        assign clear     = 1'b0;
        assign ld        = '1;
        assign dv        = {vq[NUM_LEVELS-1:0], in_valid & in_ready};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt <= done_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sample_sched_eval.sv
// Self-checking bench: an iterative (WIDTH=1) and a pipelined (WIDTH=64) instance
// checked against the netlist reduced to o=a&b&c, p=~(a|d), q=all-ones.
module tb_sample_sched_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        f_rst, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [0:0]  f_a, f_b, f_c, f_d, f_e, f_f, f_o, f_p, f_q;
    logic [15:0] f_done;

    logic        p_rst, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [63:0] p_a, p_b, p_c, p_d, p_e, p_f, p_o, p_p, p_q;
    logic [3:0]  p_done;

    logic [63:0] exp_o_q[$];
    logic [63:0] exp_p_q[$];

    sample_sched_eval #(.WIDTH(1), .MODE(0), .CNT_W(16)) u_fsm (
        .clk(clk), .rst(f_rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .a(f_a), .b(f_b), .c(f_c), .d(f_d), .e(f_e), .f(f_f),
        .out_valid(f_out_valid), .out_ready(f_out_ready),
        .o(f_o), .p(f_p), .q(f_q), .done_cnt(f_done)
    );

    sample_sched_eval #(.WIDTH(64), .MODE(1), .CNT_W(4)) u_pipe (
        .clk(clk), .rst(p_rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .a(p_a), .b(p_b), .c(p_c), .d(p_d), .e(p_e), .f(p_f),
        .out_valid(p_out_valid), .out_ready(p_out_ready),
        .o(p_o), .p(p_p), .q(p_q), .done_cnt(p_done)
    );

    // Since h=a&c forces k=1, o collapses to a&b&c; h&i is never true, so q is all ones.
    function automatic logic [63:0] ref_o(input logic [63:0] a, b, c);
        return a & b & c;
    endfunction

    function automatic logic [63:0] ref_p(input logic [63:0] a, d);
        return ~(a | d);
    endfunction

    task automatic pipe_drive_random();
        p_a = {$urandom, $urandom};
        p_b = {$urandom, $urandom};
        p_c = {$urandom, $urandom};
        p_d = {$urandom, $urandom};
        p_e = {$urandom, $urandom};
        p_f = {$urandom, $urandom};
    endtask

    task automatic pipe_reset_pulse();
        p_rst = 1'b1;
        @(posedge clk); #1;
        p_rst = 1'b0;
        exp_o_q.delete();
        exp_p_q.delete();
    endtask

    task automatic test_reset();
        f_rst = 1'b1;
        p_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (f_in_ready !== 1'b0) begin n_fail++; $display("FAIL fsm_in_ready_in_reset: got %b expected 0", f_in_ready); end
        n_checks++; if (p_in_ready !== 1'b0) begin n_fail++; $display("FAIL pipe_in_ready_in_reset: got %b expected 0", p_in_ready); end
        @(posedge clk); #1;
        f_rst = 1'b0;
        p_rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({f_in_ready, f_out_valid, f_o, f_p, f_q} !== 5'b10000) begin n_fail++; $display("FAIL fsm_reset_state: got %b expected 10000", {f_in_ready, f_out_valid, f_o, f_p, f_q}); end
        n_checks++; if (f_done !== 16'd0) begin n_fail++; $display("FAIL fsm_reset_done: got %0d expected 0", f_done); end
        n_checks++; if ({p_in_ready, p_out_valid} !== 2'b10) begin n_fail++; $display("FAIL pipe_reset_hs: got %b expected 10", {p_in_ready, p_out_valid}); end
        n_checks++; if ({p_o, p_p, p_q} !== 192'd0) begin n_fail++; $display("FAIL pipe_reset_data: got %h expected 0", {p_o, p_p, p_q}); end
        n_checks++; if (p_done !== 4'd0) begin n_fail++; $display("FAIL pipe_reset_done: got %0d expected 0", p_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_fsm_vectors();
        logic [5:0] vec [8];
        logic       eo, ep;
        int         wait_n;
        vec[0] = 6'b111000;
        vec[1] = 6'b000010;
        for (int j = 2; j < 8; j++) vec[j] = 6'($urandom);
        for (int j = 0; j < 8; j++) begin
            {f_a, f_b, f_c, f_d, f_e, f_f} = vec[j];
            eo = vec[j][5] & vec[j][4] & vec[j][3];
            ep = ~(vec[j][5] | vec[j][2]);
            f_in_valid  = 1'b1;
            f_out_ready = 1'b0;
            @(negedge clk);
            n_checks++; if (f_in_ready !== 1'b1) begin n_fail++; $display("FAIL fsm_idle_ready job %0d: got %b expected 1", j, f_in_ready); end
            @(posedge clk); #1;
            // Source keeps offering junk while busy; it must be ignored.
            {f_a, f_b, f_c, f_d, f_e, f_f} = 6'($urandom);
            for (int cyc = 1; cyc <= 4; cyc++) begin
                @(negedge clk);
                n_checks++; if ({f_out_valid, f_in_ready} !== 2'b00) begin n_fail++; $display("FAIL fsm_busy job %0d cyc %0d: got %b expected 00", j, cyc, {f_out_valid, f_in_ready}); end
                @(posedge clk); #1;
            end
            wait_n = $urandom_range(0, 2);
            for (int w = 0; w <= wait_n; w++) begin
                if (w == wait_n) f_out_ready = 1'b1;
                @(negedge clk);
                n_checks++; if ({f_out_valid, f_in_ready} !== 2'b10) begin n_fail++; $display("FAIL fsm_done_hs job %0d: got %b expected 10", j, {f_out_valid, f_in_ready}); end
                n_checks++; if ({f_o, f_p, f_q} !== {eo, ep, 1'b1}) begin n_fail++; $display("FAIL fsm_result job %0d: got %b expected %b", j, {f_o, f_p, f_q}, {eo, ep, 1'b1}); end
                @(posedge clk); #1;
            end
            f_out_ready = 1'b0;
            f_in_valid  = 1'b0;
            @(negedge clk);
            n_checks++; if ({f_out_valid, f_in_ready} !== 2'b01) begin n_fail++; $display("FAIL fsm_after_done job %0d: got %b expected 01", j, {f_out_valid, f_in_ready}); end
            n_checks++; if (f_done !== 16'(j + 1)) begin n_fail++; $display("FAIL fsm_done_cnt job %0d: got %0d expected %0d", j, f_done, j + 1); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fsm_reset_mid_job();
        int lat;
        {f_a, f_b, f_c, f_d, f_e, f_f} = 6'b111000;
        f_in_valid  = 1'b1;
        f_out_ready = 1'b1;
        @(posedge clk); #1;
        f_in_valid = 1'b0;
        @(posedge clk); #1;
        f_rst = 1'b1;
        @(negedge clk);
        n_checks++; if (f_in_ready !== 1'b0) begin n_fail++; $display("FAIL fsm_mid_rst_ready: got %b expected 0", f_in_ready); end
        @(posedge clk); #1;
        f_rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({f_in_ready, f_out_valid, f_o, f_p, f_q} !== 5'b10000) begin n_fail++; $display("FAIL fsm_mid_rst_state: got %b expected 10000", {f_in_ready, f_out_valid, f_o, f_p, f_q}); end
        n_checks++; if (f_done !== 16'd0) begin n_fail++; $display("FAIL fsm_mid_rst_done: got %0d expected 0", f_done); end
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            n_checks++; if (f_out_valid !== 1'b0) begin n_fail++; $display("FAIL fsm_discarded_job cyc %0d: got %b expected 0", cyc, f_out_valid); end
            @(posedge clk); #1;
        end
        {f_a, f_b, f_c, f_d, f_e, f_f} = 6'b111100;
        f_in_valid = 1'b1;
        @(posedge clk); #1;
        f_in_valid = 1'b0;
        for (lat = 0; lat < 10; lat++) begin
            @(negedge clk);
            if (f_out_valid) break;
            @(posedge clk); #1;
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL fsm_post_rst_latency: got %0d expected 4", lat); end
        n_checks++; if ({f_o, f_p, f_q} !== 3'b101) begin n_fail++; $display("FAIL fsm_post_rst_result: got %b expected 101", {f_o, f_p, f_q}); end
        @(posedge clk); #1;
        f_out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (f_done !== 16'd1) begin n_fail++; $display("FAIL fsm_post_rst_done: got %0d expected 1", f_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_pipe_slices();
        logic [63:0] va, vb, vc, vd;
        int          lat;
        for (int k = 0; k < 64; k++) begin
            {p_a[k], p_b[k], p_c[k], p_d[k], p_e[k], p_f[k]} = 6'(k);
        end
        va = p_a; vb = p_b; vc = p_c; vd = p_d;
        p_in_valid  = 1'b1;
        p_out_ready = 1'b1;
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        for (lat = 0; lat < 10; lat++) begin
            @(negedge clk);
            if (p_out_valid) break;
            @(posedge clk); #1;
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL pipe_latency: got %0d expected 4", lat); end
        n_checks++; if (p_o !== ref_o(va, vb, vc)) begin n_fail++; $display("FAIL slices_o: got %h expected %h", p_o, ref_o(va, vb, vc)); end
        n_checks++; if (p_p !== ref_p(va, vd)) begin n_fail++; $display("FAIL slices_p: got %h expected %h", p_p, ref_p(va, vd)); end
        n_checks++; if (p_q !== {64{1'b1}}) begin n_fail++; $display("FAIL slices_q: got %h expected all ones", p_q); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        pipe_reset_pulse();
        p_out_ready = 1'b1;
        for (int t = 0; t < 17; t++) begin
            p_in_valid = (t < 10);
            if (t < 10) pipe_drive_random();
            @(negedge clk);
            if (t < 10) begin
                n_checks++; if (p_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready t=%0d: got %b expected 1", t, p_in_ready); end
                exp_o_q.push_back(ref_o(p_a, p_b, p_c));
                exp_p_q.push_back(ref_p(p_a, p_d));
            end
            n_checks++; if (p_out_valid !== (t >= 5 && t < 15)) begin n_fail++; $display("FAIL b2b_out_valid t=%0d: got %b expected %b", t, p_out_valid, (t >= 5 && t < 15)); end
            if (p_out_valid && exp_o_q.size() > 0) begin
                n_checks++; if ({p_o, p_p, p_q} !== {exp_o_q[0], exp_p_q[0], {64{1'b1}}}) begin n_fail++; $display("FAIL b2b_data t=%0d: got %h expected %h", t, {p_o, p_p, p_q}, {exp_o_q[0], exp_p_q[0], {64{1'b1}}}); end
                void'(exp_o_q.pop_front());
                void'(exp_p_q.pop_front());
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (p_done !== 4'd10) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d expected 10", p_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        logic [191:0] held;
        logic         in_win;
        pipe_reset_pulse();
        held = '0;
        for (int t = 0; t < 22; t++) begin
            in_win      = (t >= 8 && t <= 10);
            p_in_valid  = (t < 12);
            p_out_ready = !in_win;
            if (t < 12) pipe_drive_random();
            @(negedge clk);
            if (t < 12) begin
                n_checks++; if (p_in_ready !== !in_win) begin n_fail++; $display("FAIL stall_in_ready t=%0d: got %b expected %b", t, p_in_ready, !in_win); end
                if (!in_win) begin
                    exp_o_q.push_back(ref_o(p_a, p_b, p_c));
                    exp_p_q.push_back(ref_p(p_a, p_d));
                end
            end
            if (t == 8) held = {p_o, p_p, p_q};
            if (t == 9 || t == 10) begin
                n_checks++; if ({p_out_valid, p_o, p_p, p_q} !== {1'b1, held}) begin n_fail++; $display("FAIL stall_hold t=%0d: got %h expected %h", t, {p_out_valid, p_o, p_p, p_q}, {1'b1, held}); end
            end
            if (p_out_valid && p_out_ready) begin
                n_checks++;
                if (exp_o_q.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra_output t=%0d: got an output, expected none", t);
                end else begin
                    if ({p_o, p_p, p_q} !== {exp_o_q[0], exp_p_q[0], {64{1'b1}}}) begin n_fail++; $display("FAIL stall_data t=%0d: got %h expected %h", t, {p_o, p_p, p_q}, {exp_o_q[0], exp_p_q[0], {64{1'b1}}}); end
                    void'(exp_o_q.pop_front());
                    void'(exp_p_q.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (exp_o_q.size() !== 0) begin n_fail++; $display("FAIL stall_lost_jobs: got %0d pending expected 0", exp_o_q.size()); end
        n_checks++; if (p_done !== 4'd9) begin n_fail++; $display("FAIL stall_done_cnt: got %0d expected 9", p_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_pipe_reset_mid_job();
        logic [63:0] va, vb, vc, vd;
        int          lat;
        pipe_drive_random();
        p_in_valid  = 1'b1;
        p_out_ready = 1'b1;
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        @(posedge clk); #1;
        p_rst = 1'b1;
        @(negedge clk);
        n_checks++; if (p_in_ready !== 1'b0) begin n_fail++; $display("FAIL pipe_mid_rst_ready: got %b expected 0", p_in_ready); end
        @(posedge clk); #1;
        p_rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({p_in_ready, p_out_valid, p_done} !== 6'b100000) begin n_fail++; $display("FAIL pipe_mid_rst_state: got %b expected 100000", {p_in_ready, p_out_valid, p_done}); end
        n_checks++; if ({p_o, p_p, p_q} !== 192'd0) begin n_fail++; $display("FAIL pipe_mid_rst_data: got %h expected 0", {p_o, p_p, p_q}); end
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            n_checks++; if (p_out_valid !== 1'b0) begin n_fail++; $display("FAIL pipe_discarded_job cyc %0d: got %b expected 0", cyc, p_out_valid); end
            @(posedge clk); #1;
        end
        pipe_drive_random();
        va = p_a; vb = p_b; vc = p_c; vd = p_d;
        p_in_valid = 1'b1;
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        for (lat = 0; lat < 10; lat++) begin
            @(negedge clk);
            if (p_out_valid) break;
            @(posedge clk); #1;
        end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL pipe_post_rst_latency: got %0d expected 4", lat); end
        n_checks++; if ({p_o, p_p, p_q} !== {ref_o(va, vb, vc), ref_p(va, vd), {64{1'b1}}}) begin n_fail++; $display("FAIL pipe_post_rst_data: got %h expected %h", {p_o, p_p, p_q}, {ref_o(va, vb, vc), ref_p(va, vd), {64{1'b1}}}); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (p_done !== 4'd1) begin n_fail++; $display("FAIL pipe_post_rst_done: got %0d expected 1", p_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_pipe_random();
        int accepted;
        accepted = 0;
        pipe_reset_pulse();
        for (int t = 0; t < 320; t++) begin
            if (t < 300) begin
                p_in_valid  = ($urandom_range(0, 9) < 7);
                p_out_ready = ($urandom_range(0, 9) < 6);
                pipe_drive_random();
            end else begin
                p_in_valid  = 1'b0;
                p_out_ready = 1'b1;
            end
            @(negedge clk);
            n_checks++; if (p_in_ready !== !(p_out_valid && !p_out_ready)) begin n_fail++; $display("FAIL rand_in_ready t=%0d: got %b expected %b", t, p_in_ready, !(p_out_valid && !p_out_ready)); end
            if (p_in_valid && p_in_ready) begin
                accepted++;
                exp_o_q.push_back(ref_o(p_a, p_b, p_c));
                exp_p_q.push_back(ref_p(p_a, p_d));
            end
            if (p_out_valid && p_out_ready) begin
                n_checks++;
                if (exp_o_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_output t=%0d: got an output, expected none", t);
                end else begin
                    if ({p_o, p_p, p_q} !== {exp_o_q[0], exp_p_q[0], {64{1'b1}}}) begin n_fail++; $display("FAIL rand_data t=%0d: got %h expected %h", t, {p_o, p_p, p_q}, {exp_o_q[0], exp_p_q[0], {64{1'b1}}}); end
                    void'(exp_o_q.pop_front());
                    void'(exp_p_q.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (exp_o_q.size() !== 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending expected 0", exp_o_q.size()); end
        n_checks++; if (p_done !== 4'(accepted)) begin n_fail++; $display("FAIL rand_done_wrap: got %0d expected %0d", p_done, 4'(accepted)); end
        @(posedge clk); #1;
    endtask

    initial begin
        f_in_valid = 1'b0; f_out_ready = 1'b0;
        {f_a, f_b, f_c, f_d, f_e, f_f} = '0;
        p_in_valid = 1'b0; p_out_ready = 1'b0;
        p_a = '0; p_b = '0; p_c = '0; p_d = '0; p_e = '0; p_f = '0;
        test_reset();
        test_fsm_vectors();
        test_fsm_reset_mid_job();
        test_pipe_slices();
        test_back_to_back();
        test_stall();
        test_pipe_reset_mid_job();
        test_pipe_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/sample_sched_eval.md
# sample_sched_eval

Parametrised, level-scheduled evaluator for the six-input/three-output `sample` logic netlist. It is the sequential successor of the purely combinational form: it evaluates WIDTH independent bit-slices in parallel, one ASAP logic level per clock. The valid/ready handshake on both sides lets it sit between an input-vector source and a result sink in the scheduling test harness. MODE selects one job in flight at a time (iterative FSM) or one job per cycle (4-stage pipeline).

## Interface
- WIDTH, 8, number of independent bit-slices evaluated per job (≥1)
- MODE, 0, 0 = iterative FSM, 1 = fully pipelined
- CNT_W, 16, width of completed-job counter
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input job valid
- in_ready  out  1  input job accepted when in_valid & in_ready
- a, b, c, d, e, f  in  WIDTH each  primary inputs, bit k = slice k
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- o, p, q  out  WIDTH each  primary outputs
- done_cnt  out  CNT_W  count of completed output handshakes

## Operation
- Logic is bitwise across slices:
  - L1: g=a|d, h=a&c, i=~c, j=d|e|f
  - L2: k=g|h|i, l=h&j&i, m=i&j, p=~g
  - L3: n=l&m, o=b&k&h
  - L4: q=~n
- Each level is registered. Values needed later (b, h, p, o) are carried forward through the stage registers.
- MODE=0 FSM states: IDLE, L1, L2, L3, L4, DONE.
  - IDLE→L1 on input handshake; operands are captured.
  - L1→L2→L3→L4→DONE unconditionally, one cycle each.
  - DONE→IDLE on output handshake.
  - in_ready = (state==IDLE); out_valid = (state==DONE).
- MODE=1: four stage registers, each with a valid bit.
  - Global stall = out_valid & ~out_ready. Stall freezes all stages, including bubbles.
  - in_ready = ~stall.
- done_cnt increments on every output handshake and wraps modulo 2^CNT_W.
- Because h & i ≡ 0, n ≡ 0 and q ≡ all-ones. The datapath still computes q; it is not constant-folded.

## Timing
- Reset values: in_ready=0 in reset cycle, then 1 (both modes); out_valid=0; o,p,q=0; done_cnt=0; FSM=IDLE; all pipeline valids=0.
- Latency: input handshake at edge E0 → out_valid high after edge E4 (4 cycles), both modes.
- MODE=0 throughput: at most one job per 6 cycles (accept, 4 levels, DONE handshake, IDLE).
- MODE=1 throughput: one job per cycle with out_ready held high.
- Outputs hold stable while out_valid & ~out_ready.
- rst asserted mid-job discards all in-flight jobs. The next cycle matches the reset state. done_cnt clears.
- MODE=1 with a simultaneous output handshake and input handshake in the same cycle: both complete, with no bubble inserted.
- in_valid while in_ready=0: ignored. The source must hold its data.

## Structure
- Package sample_sched_pkg holds:
  - state enum: IDLE, L1, L2, L3, L4, DONE
  - localparam NUM_LEVELS=4
  - level-function helpers (l1..l4), shared by both modes
- Sub-module sample_stage_reg: WIDTH-generic data register plus valid bit, with load/stall/clear. Instantiated per level in MODE=1 and reused as the operand/result registers in MODE=0.
- Top-level generate selects the FSM or pipeline control on MODE.

## Test plan
- WIDTH=1, MODE=0: a=1,b=1,c=1,d=e=f=0 → after 4 cycles o=1,p=0,q=1; done_cnt=1.
- WIDTH=1, MODE=0: a=b=c=d=f=0,e=1 → o=0,p=1,q=1.
  - in_ready stays low from E0 until the cycle after the output handshake.
- WIDTH=64, MODE=1: slice k = 6-bit value k applied to {a..f} → every slice matches the reference equations; q=all-ones.
- MODE=1, 10 back-to-back jobs with out_ready=1 → 10 results on consecutive cycles starting at E4, in order; done_cnt=10.
- MODE=1, out_ready low for 3 cycles mid-stream → outputs frozen, in_ready=0 during the stall, no job lost or duplicated.
- Either mode, rst pulsed at L2 of a job → no out_valid for that job; done_cnt=0; the next job completes normally.
